// File: rtl/pipeline_stage_ctrl_pkg.sv
// pipeline_stage_ctrl_pkg: FSM state encodings and STAGES legality helper for the pipeline controller
package pipeline_stage_ctrl_pkg;
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_HALTED = 2'd2} state_t;
  function automatic bit stages_legal(input int s);
    return s >= 2 && s <= 16;
  endfunction
endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: CNT_W-bit event counter that saturates at all-ones, cleared by sync reset
module pipe_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk)
    count <= reset ? '0 : (inc && !(&count)) ? count + CNT_W'(1) : count;
endmodule

// File: rtl/pipeline_stage_ctrl.sv
// pipeline_stage_ctrl: per-stage valid/enable control with stall, flush, halt/drain/resume (PIPE_CTRL_PERF_EN adds counters)
module pipeline_stage_ctrl
  import pipeline_stage_ctrl_pkg::*;
#(
  parameter int STAGES = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ena,
  input  logic [STAGES-1:0] stall_req,
  input  logic [STAGES-1:0] flush_req,
  input  logic              halt_req,
  input  logic              resume,
  output logic [STAGES-1:0] stage_ena,
  output logic [STAGES-1:0] stage_valid,
  output logic              pipe_empty,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  bubble_count,
  output logic [CNT_W-1:0]  flush_count
);
  state_t state, nxt_state;
  logic [STAGES-1:0] hold, kill, nxt_valid;
  logic fetch_go;
  if (!stages_legal(STAGES)) begin : g_bad_stages
    $error("pipeline_stage_ctrl: STAGES must be 2..16");
  end
  assign fetch_go = ena & (state == ST_RUN);
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    assign hold[k] = |stall_req[STAGES-1:k];
    if (k == STAGES - 1) begin : g_last
      assign kill[k] = 1'b0;
    end else begin : g_mid
      assign kill[k] = |flush_req[STAGES-1:k+1];
    end
    if (k == 0) begin : g_first
      assign nxt_valid[k] = ~kill[k] & (hold[k] ? stage_valid[k] : fetch_go);
    end else begin : g_rest
      assign nxt_valid[k] = ~kill[k] & (hold[k] ? stage_valid[k] : ~hold[k-1] & stage_valid[k-1]);
    end
  end
  assign stage_ena  = ~hold;
  assign pipe_empty = ~|stage_valid;
  assign halted     = state == ST_HALTED;
  always_ff @(posedge clk) begin
    stage_valid <= reset ? '0 : nxt_valid;
    state       <= reset ? ST_RUN : nxt_state;
  end
  always_comb begin
    nxt_state = state;
    nxt_state = state == ST_RUN   ? (halt_req   ? ST_DRAIN  : ST_RUN)
              : state == ST_DRAIN ? (pipe_empty ? ST_HALTED : ST_DRAIN)
              : (resume ? ST_RUN : ST_HALTED);
  end
`ifdef PIPE_CTRL_PERF_EN
  logic bubble;
  assign bubble = |(~hold[STAGES-1:1] & hold[STAGES-2:0] & ~kill[STAGES-1:1]);
  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall (.clk(clk), .reset(reset), .inc(|stall_req), .count(stall_cycles));
  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble (.clk(clk), .reset(reset), .inc(bubble), .count(bubble_count));
  pipe_sat_counter #(.CNT_W(CNT_W)) u_flush (.clk(clk), .reset(reset), .inc(|flush_req), .count(flush_count));
`else
  assign stall_cycles = '0;
  assign bubble_count = '0;
  assign flush_count  = '0;
`endif
endmodule

// File: tb/tb_pipeline_stage_ctrl.sv
// tb_pipeline_stage_ctrl: directed vectors plus per-cycle comparison against an occupancy-level pipeline model
module tb_pipeline_stage_ctrl;
  localparam int S = 5;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, ena = 1'b0, halt_req = 1'b0, resume = 1'b0;
  logic [S-1:0] stall_req = '0, flush_req = '0;
  logic [S-1:0] stage_ena, stage_valid, s_ena, s_valid;
  logic pipe_empty, halted, s_empty, s_halted;
  logic [31:0] stall_cycles, bubble_count, flush_count;
  logic [2:0] s_stall, s_bubble, s_flush;
  int vectors = 0, miscompares = 0;
  int occ[S];
  int mstate = 0, next_id = 1;
  longint m_stall = 0, m_bubble = 0, m_flush = 0;
  bit started = 1'b0;
  always #5 clk = ~clk;
  pipeline_stage_ctrl #(.STAGES(S), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .ena(ena), .stall_req(stall_req), .flush_req(flush_req),
    .halt_req(halt_req), .resume(resume), .stage_ena(stage_ena), .stage_valid(stage_valid),
    .pipe_empty(pipe_empty), .halted(halted), .stall_cycles(stall_cycles),
    .bubble_count(bubble_count), .flush_count(flush_count));
  pipeline_stage_ctrl #(.STAGES(S), .CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .ena(ena), .stall_req(stall_req), .flush_req(flush_req),
    .halt_req(halt_req), .resume(resume), .stage_ena(s_ena), .stage_valid(s_valid),
    .pipe_empty(s_empty), .halted(s_halted), .stall_cycles(s_stall),
    .bubble_count(s_bubble), .flush_count(s_flush));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int top_idx(input logic [S-1:0] v);
    int r = -1;
    for (int i = 0; i < S; i++) if (v[i]) r = i;
    return r;
  endfunction
  function automatic logic [S-1:0] model_valid();
    logic [S-1:0] v;
    for (int i = 0; i < S; i++) v[i] = occ[i] != 0;
    return v;
  endfunction
  function automatic logic [63:0] sat(input longint v, input longint lim);
    return PERF ? 64'(v > lim ? lim : v) : 64'd0;
  endfunction
  always @(posedge clk) begin : model
    int hs, hf;
    int n[S];
    bit empty;
    hs = top_idx(stall_req);
    hf = top_idx(flush_req);
    empty = model_valid() == '0;
    if (reset) begin
      for (int i = 0; i < S; i++) occ[i] = 0;
      mstate = 0;
      m_stall = 0;
      m_bubble = 0;
      m_flush = 0;
    end else begin
      for (int k = 0; k < S; k++) begin
        if (k < hf) n[k] = 0;
        else if (k <= hs) n[k] = occ[k];
        else if (k == 0) begin
          n[k] = (ena && mstate == 0) ? next_id : 0;
          if (n[k] != 0) next_id++;
        end
        else if (k - 1 <= hs) n[k] = 0;
        else n[k] = occ[k-1];
      end
      if (stall_req != '0) m_stall++;
      if (flush_req != '0) m_flush++;
      if (hs >= 0 && hs < S - 1 && !(hf > hs + 1)) m_bubble++;
      case (mstate)
        0: mstate = halt_req ? 1 : 0;
        1: mstate = empty ? 2 : 1;
        default: mstate = resume ? 0 : 2;
      endcase
      for (int i = 0; i < S; i++) occ[i] = n[i];
    end
    started = 1'b1;
  end
  always @(negedge clk) begin : compare
    logic [S-1:0] e_ena, e_valid;
    if (started) begin
      e_valid = model_valid();
      for (int k = 0; k < S; k++) e_ena[k] = k > top_idx(stall_req);
      chk("stage_valid", stage_valid, e_valid);
      chk("stage_ena", stage_ena, e_ena);
      chk("pipe_empty", pipe_empty, e_valid == '0);
      chk("halted", halted, mstate == 2);
      chk("stall_cycles", stall_cycles, sat(m_stall, 64'hFFFF_FFFF));
      chk("bubble_count", bubble_count, sat(m_bubble, 64'hFFFF_FFFF));
      chk("flush_count", flush_count, sat(m_flush, 64'hFFFF_FFFF));
      chk("sat_valid", s_valid, e_valid);
      chk("sat_ena", s_ena, e_ena);
      chk("sat_halted", s_halted, mstate == 2);
      chk("sat_empty", s_empty, e_valid == '0);
      chk("sat_stall_cycles", s_stall, sat(m_stall, 7));
      chk("sat_bubble_count", s_bubble, sat(m_bubble, 7));
      chk("sat_flush_count", s_flush, sat(m_flush, 7));
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin : stim
    logic [S-1:0] fill_tab [5];
    int n;
    fill_tab = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111};
    repeat (2) step();
    chk("reset_valid", stage_valid, 0);
    chk("reset_halted", halted, 0);
    chk("reset_stall_cycles", stall_cycles, 0);
    reset = 1'b0;
    ena = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("fill", stage_valid, fill_tab[i]);
    end
    stall_req = 5'b00100;
    #1;
    chk("stall_ena", stage_ena, 5'b11000);
    step();
    chk("stall_bubble", stage_valid, 5'b10111);
    step();
    stall_req = '0;
    chk("stall_bubble_count", bubble_count, PERF ? 2 : 0);
    chk("stall_cycles", stall_cycles, PERF ? 2 : 0);
    repeat (5) step();
    flush_req = 5'b01000;
    step();
    flush_req = '0;
    chk("flush_valid", stage_valid, 5'b11000);
    chk("flush_count", flush_count, PERF ? 1 : 0);
    repeat (5) step();
    stall_req = 5'b00010;
    flush_req = 5'b00100;
    #1;
    chk("flush_stall_ena", stage_ena, 5'b11100);
    step();
    stall_req = '0;
    flush_req = '0;
    chk("flush_stall_valid", stage_valid, 5'b11000);
    repeat (5) step();
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    n = 0;
    while (stage_valid != '0 && n < 20) begin
      step();
      n++;
    end
    chk("drain_cycles", n, 5);
    chk("drain_not_halted", halted, 0);
    step();
    chk("drain_halted", halted, 1);
    step();
    chk("halted_no_fetch", stage_valid, 0);
    resume = 1'b1;
    step();
    resume = 1'b0;
    chk("resume_halted", halted, 0);
    step();
    chk("resume_fetch", stage_valid, 5'b00001);
    halt_req = 1'b1;
    n = 0;
    while (!halted && n < 20) begin
      step();
      n++;
    end
    chk("rehalt", halted, 1);
    resume = 1'b1;
    step();
    resume = 1'b0;
    chk("resume_beats_halt", halted, 0);
    step();
    step();
    halt_req = 1'b0;
    chk("redrain_no_fetch", stage_valid[0], 0);
    stall_req = 5'b00010;
    step();
    reset = 1'b1;
    step();
    chk("midreset_valid", stage_valid, 0);
    chk("midreset_halted", halted, 0);
    chk("midreset_stall_cycles", stall_cycles, 0);
    chk("midreset_bubble_count", bubble_count, 0);
    reset = 1'b0;
    stall_req = 5'b00001;
    repeat (9) step();
    stall_req = '0;
    chk("sat_stick", s_stall, PERF ? 7 : 0);
    chk("nosat_stall", stall_cycles, PERF ? 9 : 0);
    repeat (2) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
